router_pkt_tx: RTL

Packet source for the 1x3 router: accepts a packet request (destination address, payload length, payload bytes), buffers the payload, and drives it onto the router input port. It sends a header byte, then the payload bytes, then an XOR parity byte, using the router's `pkt_valid` and `busy` handshake. It sits in front of the router's input (`data_in` / `pkt_valid` / `busy`) and serves as the reusable stimulus/traffic source for router-level test and integration.

---
 rtl/router_pkt_tx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port.
// Accepts a request (addr, len, corrupt) and len payload bytes. It then sends
// a header byte {len, addr}, the payload bytes, and an XOR parity byte, using
// the router's pkt_valid/busy handshake. After the parity byte it forces
// GAP_CYCLES idle cycles, pulsing done in the last one.
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   start/addr/len/    packet request, sampled only in IDLE
//   corrupt
//   wr_en/wr_data      payload byte writes, accepted while in_ready=1
//   in_ready           payload bytes are being accepted
//   busy               router busy; the presented byte holds while high
//   pkt_valid/data_out byte stream to the router
//   tx_busy            high outside IDLE
//   done               one-cycle pulse in the last GAP cycle
//   cfg_err            one-cycle pulse on an illegal start (addr==3 or len==0)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | accepting payload bytes into the buffer
// HDR   | header byte presented
// PLD   | payload byte rd_ptr presented
// PAR   | parity byte presented (pkt_valid low)
// GAP   | inter-packet gap, down-counter to zero

module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    input  logic       corrupt,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       in_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_busy,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PLD,
        S_PAR,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] pld_mem [0:62];
    logic       mem_we;

    logic [5:0] wr_ptr, wr_ptr_nxt;
    logic [5:0] rd_ptr, rd_ptr_nxt;
    logic [1:0] addr_q, addr_nxt;
    logic [5:0] len_q, len_nxt;
    logic       corrupt_q, corrupt_nxt;
    logic [7:0] parity, parity_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;

    logic       in_ready_nxt;
    logic       pkt_valid_nxt;
    logic [7:0] data_out_nxt;
    logic       tx_busy_nxt;
    logic       done_nxt;
    logic       cfg_err_nxt;

    logic [5:0] len_m1;
    logic [5:0] rd_ptr_inc;
    logic [7:0] header;

    assign len_m1     = len_q - 6'd1;
    assign rd_ptr_inc = rd_ptr + 6'd1;
    assign header     = {len_q, addr_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            corrupt_q <= 1'b0;
            parity    <= '0;
            gap_cnt   <= '0;
            in_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_busy   <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            addr_q    <= addr_nxt;
            len_q     <= len_nxt;
            corrupt_q <= corrupt_nxt;
            parity    <= parity_nxt;
            gap_cnt   <= gap_cnt_nxt;
            in_ready  <= in_ready_nxt;
            pkt_valid <= pkt_valid_nxt;
            data_out  <= data_out_nxt;
            tx_busy   <= tx_busy_nxt;
            done      <= done_nxt;
            cfg_err   <= cfg_err_nxt;
        end
    end

    // Payload storage has no reset; contents are only read after being
    // written in the same packet.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            pld_mem[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        addr_nxt      = addr_q;
        len_nxt       = len_q;
        corrupt_nxt   = corrupt_q;
        parity_nxt    = parity;
        gap_cnt_nxt   = gap_cnt;
        in_ready_nxt  = in_ready;
        pkt_valid_nxt = pkt_valid;
        data_out_nxt  = data_out;
        done_nxt      = 1'b0;
        cfg_err_nxt   = 1'b0;
        mem_we        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (addr == 2'd3 || len == 6'd0) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        addr_nxt     = addr;
                        len_nxt      = len;
                        corrupt_nxt  = corrupt;
                        parity_nxt   = {len, addr};
                        wr_ptr_nxt   = '0;
                        rd_ptr_nxt   = '0;
                        in_ready_nxt = 1'b1;
                        state_nxt    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    mem_we     = 1'b1;
                    parity_nxt = parity ^ wr_data;
                    wr_ptr_nxt = wr_ptr + 6'd1;
                    if (wr_ptr == len_m1) begin
                        in_ready_nxt  = 1'b0;
                        data_out_nxt  = header;
                        pkt_valid_nxt = 1'b1;
                        state_nxt     = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!busy) begin
                    data_out_nxt = pld_mem[0];
                    rd_ptr_nxt   = '0;
                    state_nxt    = S_PLD;
                end
            end
            S_PLD: begin
                if (!busy) begin
                    if (rd_ptr == len_m1) begin
                        // parity already includes every payload byte written
                        data_out_nxt  = parity ^ {7'd0, corrupt_q};
                        pkt_valid_nxt = 1'b0;
                        state_nxt     = S_PAR;
                    end else begin
                        rd_ptr_nxt   = rd_ptr_inc;
                        data_out_nxt = pld_mem[rd_ptr_inc];
                    end
                end
            end
            S_PAR: begin
                if (!busy) begin
                    data_out_nxt = '0;
                    gap_cnt_nxt  = GAP_LOAD;
                    done_nxt     = (GAP_LOAD == 4'd0);
                    state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                // done is registered, so it is raised on the edge entering
                // the final gap cycle (terminal count reached next).
                if (gap_cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                    done_nxt    = (gap_cnt == 4'd1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        tx_busy_nxt = (state_nxt != S_IDLE);
    end

endmodule
